// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads to
// instruction memory and queues returned words with their PCs for decode.
module instr_fetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] tag_mem   [DEPTH];

  logic        fire, push, pop, drop;
  logic [CW:0] in_use;

  assign in_use    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_addr = pc_q;

  always_comb begin
    // A request is only allowed when a FIFO slot is guaranteed for its response.
    imem_req_valid = rst_n && !redirect_valid && (in_use < DEPTH_W);
    fire           = imem_req_valid && imem_req_ready;
    if_valid       = (count_q != '0);
    drop           = (drop_cnt_q != '0) || redirect_valid;
    push           = imem_rsp_valid && !drop;
    pop            = if_valid && if_ready && !redirect_valid;
    if_instr       = if_valid ? instr_mem[rd_ptr_q] : '0;
    if_pc          = if_valid ? pc_mem[rd_ptr_q] : '0;
    if_pc_plus4    = if_valid ? (pc_mem[rd_ptr_q] + 32'd4) : '0;
  end

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tag_wr_d      = fire ? tag_wr_q + AW'(1) : tag_wr_q;
    tag_rd_d      = imem_rsp_valid ? tag_rd_q + AW'(1) : tag_rd_q;

    if (redirect_valid) begin
      // Everything still in flight belongs to the old path.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      wr_ptr_d   = rd_ptr_q;
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC & 32'hFFFF_FFFC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

  // Storage needs no reset: the counters decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (fire) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule
